// File: rtl/tdm_lane_gather.sv
// tdm_lane_gather
// A shared byte stream is time-division multiplexed across NUM_LANES lanes.
// Each lane assembles bytes into WORD_BYTES-wide words, parks a completed word
// in a single pending register, and a round-robin arbiter moves pending words
// into one registered output stage with a valid/ready handshake.
module tdm_lane_gather #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 4,
  parameter int WORD_BYTES = 60,
  parameter int CTL_WIDTH  = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic                               in_new_packet,
  input  logic [DATA_WIDTH-1:0]              in_data,
  input  logic                               slot_sync,
  output logic [$clog2(NUM_LANES)-1:0]       slot,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(NUM_LANES)-1:0]       out_lane,
  output logic [CTL_WIDTH-1:0]               out_ctl,
  output logic [WORD_BYTES*DATA_WIDTH-1:0]   out_data,
  output logic [15:0]                        drop_count
);

  localparam int LW = $clog2(NUM_LANES);
  localparam int WW = WORD_BYTES * DATA_WIDTH;

  // Lane index arithmetic modulo NUM_LANES; lane counts need not be powers of 2.
  function automatic logic [LW-1:0] lane_add(input logic [LW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_LANES) s = s - NUM_LANES;
    return LW'(s);
  endfunction

  // Per-lane assembly state
  logic [WW-1:0]          asm_data [NUM_LANES];
  logic [7:0]             asm_cnt  [NUM_LANES];
  logic [NUM_LANES-1:0]   asm_sop;

  // Per-lane pending word
  logic [NUM_LANES-1:0]   pend_vld;
  logic [WW-1:0]          pend_data [NUM_LANES];
  logic [7:0]             pend_cnt  [NUM_LANES];
  logic [NUM_LANES-1:0]   pend_sop;
  logic [NUM_LANES-1:0]   pend_eop;

  // Current-slot assembly results
  logic [WW-1:0]          cur_data;
  logic [7:0]             cur_cnt;
  logic                   cur_sop;
  logic [WW-1:0]          app_data;
  logic [WW-1:0]          nxt_data;
  logic [7:0]             nxt_cnt;
  logic                   nxt_sop;
  logic                   cmp_vld;
  logic [WW-1:0]          cmp_data;
  logic [7:0]             cmp_cnt;
  logic                   cmp_sop;
  logic                   cmp_eop;

  // Arbitration / output stage control
  logic [LW-1:0]          rr_ptr;
  logic [LW-1:0]          rr_nxt;
  logic [LW-1:0]          cand;
  logic                   load_en;
  logic                   gnt_vld;
  logic [LW-1:0]          gnt_lane;
  logic                   drain;
  logic                   drop;
  logic [CTL_WIDTH-1:0]   ctl_nxt;

  // Apply this cycle's byte to the lane owning the slot and detect word completion.
  always_comb begin
    cur_data = asm_data[slot];
    cur_cnt  = asm_cnt[slot];
    cur_sop  = asm_sop[slot];

    // A word that is empty starts from all-zero so unfilled bytes read as 0.
    app_data = (cur_cnt == 8'd0) ? '0 : cur_data;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (cur_cnt == 8'(b)) app_data[b*DATA_WIDTH +: DATA_WIDTH] = in_data;
    end

    nxt_data = cur_data;
    nxt_cnt  = cur_cnt;
    nxt_sop  = cur_sop;
    cmp_vld  = 1'b0;
    cmp_data = cur_data;
    cmp_cnt  = cur_cnt;
    cmp_sop  = cur_sop;
    cmp_eop  = 1'b0;

    if (in_valid && in_new_packet) begin
      // New packet closes any partial word as end-of-packet, then starts fresh.
      if (cur_cnt != 8'd0) begin
        cmp_vld = 1'b1;
        cmp_eop = 1'b1;
      end
      nxt_data                   = '0;
      nxt_data[DATA_WIDTH-1:0]   = in_data;
      nxt_cnt                    = 8'd1;
      nxt_sop                    = 1'b1;
    end else if (in_valid) begin
      if (cur_cnt == 8'(WORD_BYTES - 1)) begin
        cmp_vld  = 1'b1;
        cmp_data = app_data;
        cmp_cnt  = 8'(WORD_BYTES);
        cmp_sop  = cur_sop;
        cmp_eop  = 1'b0;
        nxt_data = '0;
        nxt_cnt  = 8'd0;
        nxt_sop  = 1'b0;
      end else begin
        nxt_data = app_data;
        nxt_cnt  = cur_cnt + 8'd1;
        // A word opened without new_packet is a continuation, never sop.
        nxt_sop  = (cur_cnt == 8'd0) ? 1'b0 : cur_sop;
      end
    end else if (cur_cnt != 8'd0) begin
      // An idle slot on a lane with bytes in flight marks end of packet.
      cmp_vld  = 1'b1;
      cmp_eop  = 1'b1;
      nxt_data = '0;
      nxt_cnt  = 8'd0;
      nxt_sop  = 1'b0;
    end
  end

  // Round-robin pick among occupied pending registers and drop detection.
  always_comb begin
    load_en  = !out_valid || out_ready;
    gnt_vld  = 1'b0;
    gnt_lane = '0;
    cand     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand = lane_add(rr_ptr, i);
      if (!gnt_vld && pend_vld[cand]) begin
        gnt_vld  = 1'b1;
        gnt_lane = cand;
      end
    end
    drain  = load_en && gnt_vld;
    rr_nxt = lane_add(gnt_lane, 1);
    // Draining and refilling the same pending register in one cycle is not a drop.
    drop   = cmp_vld && pend_vld[slot] && !(drain && (gnt_lane == slot));
  end

  // Control sideband for the granted pending word.
  always_comb begin
    ctl_nxt        = '0;
    ctl_nxt[7:0]   = pend_cnt[gnt_lane];
    ctl_nxt[15:8]  = 8'(gnt_lane);
    ctl_nxt[16]    = pend_sop[gnt_lane];
    ctl_nxt[17]    = pend_eop[gnt_lane];
  end

  // Slot rotation; sync takes effect on the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot <= '0;
    end else if (slot_sync) begin
      slot <= '0;
    end else begin
      slot <= lane_add(slot, 1);
    end
  end

  // Assembly registers: only the lane owning the slot changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        asm_data[i] <= '0;
        asm_cnt[i]  <= '0;
      end
      asm_sop <= '0;
    end else begin
      asm_data[slot] <= nxt_data;
      asm_cnt[slot]  <= nxt_cnt;
      asm_sop[slot]  <= nxt_sop;
    end
  end

  // Pending registers: load on completion unless dropped, clear when drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        pend_data[i] <= '0;
        pend_cnt[i]  <= '0;
      end
      pend_vld <= '0;
      pend_sop <= '0;
      pend_eop <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (cmp_vld && (slot == LW'(i)) && !drop) begin
          pend_vld[i]  <= 1'b1;
          pend_data[i] <= cmp_data;
          pend_cnt[i]  <= cmp_cnt;
          pend_sop[i]  <= cmp_sop;
          pend_eop[i]  <= cmp_eop;
        end else if (drain && (gnt_lane == LW'(i))) begin
          pend_vld[i]  <= 1'b0;
        end
      end
    end
  end

  // Output stage: refills when empty or when the current word is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_ctl   <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_lane <= gnt_lane;
        out_ctl  <= ctl_nxt;
        out_data <= pend_data[gnt_lane];
        rr_ptr   <= rr_nxt;
      end
    end
  end

  // Saturating count of words lost to an occupied pending register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_tdm_lane_gather.sv
// Bench for tdm_lane_gather: a 3-lane and a 4-lane instance (4-byte words)
// share one stimulus set, gated by sel_a; expected words go to per-instance
// queues and are popped by a negedge monitor on each accepted output.
module tb_tdm_lane_gather;

  localparam int DW = 8;
  localparam int CW = 32;
  localparam int WB = 4;
  localparam int NA = 3;
  localparam int NB = 4;

  typedef struct packed {
    logic [1:0]  lane;
    logic [31:0] ctl;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sel_a;
  logic       in_valid;
  logic       in_new_packet;
  logic [7:0] in_data;
  logic       slot_sync;
  logic       out_ready;

  logic [1:0]  a_slot, a_out_lane, b_slot, b_out_lane;
  logic        a_out_valid, b_out_valid;
  logic [31:0] a_out_ctl, a_out_data, b_out_ctl, b_out_data;
  logic [15:0] a_drop, b_drop;

  int tests_run = 0;
  int tests_failed = 0;

  exp_t a_q[$];
  exp_t b_q[$];

  logic [1:0] a_mslot, b_mslot;

  tdm_lane_gather #(.DATA_WIDTH(DW), .NUM_LANES(NA), .WORD_BYTES(WB), .CTL_WIDTH(CW)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & sel_a), .in_new_packet(in_new_packet & sel_a),
    .in_data(in_data), .slot_sync(slot_sync & sel_a),
    .slot(a_slot), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_lane(a_out_lane), .out_ctl(a_out_ctl), .out_data(a_out_data),
    .drop_count(a_drop)
  );

  tdm_lane_gather #(.DATA_WIDTH(DW), .NUM_LANES(NB), .WORD_BYTES(WB), .CTL_WIDTH(CW)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & ~sel_a), .in_new_packet(in_new_packet & ~sel_a),
    .in_data(in_data), .slot_sync(slot_sync & ~sel_a),
    .slot(b_slot), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_lane(b_out_lane), .out_ctl(b_out_ctl), .out_data(b_out_data),
    .drop_count(b_drop)
  );

  // Reference slot counters
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_mslot <= '0;
      b_mslot <= '0;
    end else begin
      if (slot_sync && sel_a)              a_mslot <= '0;
      else if (a_mslot == 2'(NA - 1))      a_mslot <= '0;
      else                                 a_mslot <= a_mslot + 2'd1;
      if (slot_sync && !sel_a)             b_mslot <= '0;
      else if (b_mslot == 2'(NB - 1))      b_mslot <= '0;
      else                                 b_mslot <= b_mslot + 2'd1;
    end
  end

  // Scoreboard monitor: slot tracking and accepted-word checks
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      tests_run++;
      if (a_slot !== a_mslot) begin
        tests_failed++;
        $display("FAIL a_slot got %0d want %0d at %0t", a_slot, a_mslot, $time);
      end
      tests_run++;
      if (b_slot !== b_mslot) begin
        tests_failed++;
        $display("FAIL b_slot got %0d want %0d at %0t", b_slot, b_mslot, $time);
      end
      if (a_out_valid === 1'b1 && out_ready === 1'b1) begin
        tests_run++;
        if (a_q.size() == 0) begin
          tests_failed++;
          $display("FAIL a_unexpected_word lane %0d ctl %h data %h", a_out_lane, a_out_ctl, a_out_data);
        end else begin
          e = a_q.pop_front();
          if (a_out_lane !== e.lane || a_out_ctl !== e.ctl || a_out_data !== e.data) begin
            tests_failed++;
            $display("FAIL a_word got lane %0d ctl %h data %h want lane %0d ctl %h data %h",
                     a_out_lane, a_out_ctl, a_out_data, e.lane, e.ctl, e.data);
          end
        end
      end
      if (b_out_valid === 1'b1 && out_ready === 1'b1) begin
        tests_run++;
        if (b_q.size() == 0) begin
          tests_failed++;
          $display("FAIL b_unexpected_word lane %0d ctl %h data %h", b_out_lane, b_out_ctl, b_out_data);
        end else begin
          e = b_q.pop_front();
          if (b_out_lane !== e.lane || b_out_ctl !== e.ctl || b_out_data !== e.data) begin
            tests_failed++;
            $display("FAIL b_word got lane %0d ctl %h data %h want lane %0d ctl %h data %h",
                     b_out_lane, b_out_ctl, b_out_data, e.lane, e.ctl, e.data);
          end
        end
      end
    end
  end

  function automatic exp_t mk_exp(input int lane, input int cnt, input bit sop, input bit eop,
                                  input logic [31:0] d);
    exp_t e;
    e.lane      = 2'(lane);
    e.ctl       = '0;
    e.ctl[7:0]  = 8'(cnt);
    e.ctl[15:8] = 8'(lane);
    e.ctl[16]   = sop;
    e.ctl[17]   = eop;
    e.data      = d;
    return e;
  endfunction

  task automatic step(input logic v, input logic np, input logic [7:0] d, input logic sy);
    in_valid      = v;
    in_new_packet = np;
    in_data       = d;
    slot_sync     = sy;
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    in_new_packet = 1'b0;
    in_data       = 8'h00;
    slot_sync     = 1'b0;
  endtask

  task automatic goto_lane(input int lane);
    int n;
    n = 0;
    while (int'(sel_a ? a_mslot : b_mslot) != lane && n < 20) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      n++;
    end
    if (n >= 20) begin
      tests_run++;
      tests_failed++;
      $display("FAIL goto_lane timeout lane %0d", lane);
    end
  endtask

  task automatic send(input int lane, input logic v, input logic np, input logic [7:0] d);
    goto_lane(lane);
    step(v, np, d, 1'b0);
  endtask

  task automatic test_reset();
    int seq[3];
    seq = '{1, 2, 0};
    #1 rst = 1'b0;
    #11;
    tests_run++;
    if ({a_out_valid, a_out_lane, a_out_ctl, a_out_data, a_drop, a_slot} !== '0) begin
      tests_failed++;
      $display("FAIL reset_a got v%0d lane %0d ctl %h data %h drop %0d slot %0d want all 0",
               a_out_valid, a_out_lane, a_out_ctl, a_out_data, a_drop, a_slot);
    end
    tests_run++;
    if ({b_out_valid, b_out_lane, b_out_ctl, b_out_data, b_drop, b_slot} !== '0) begin
      tests_failed++;
      $display("FAIL reset_b got v%0d lane %0d ctl %h data %h drop %0d slot %0d want all 0",
               b_out_valid, b_out_lane, b_out_ctl, b_out_data, b_drop, b_slot);
    end
    rst = 1'b1;
    tests_run++;
    if (a_slot !== 2'd0) begin
      tests_failed++;
      $display("FAIL slot_seq_a0 got %0d want 0", a_slot);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (int'(a_slot) != seq[i]) begin
        tests_failed++;
        $display("FAIL slot_seq_a%0d got %0d want %0d", i + 1, a_slot, seq[i]);
      end
    end
  endtask

  task automatic test_word_a();
    send(1, 1'b1, 1'b1, 8'h11);
    send(1, 1'b1, 1'b0, 8'h22);
    send(1, 1'b1, 1'b0, 8'h33);
    a_q.push_back(mk_exp(1, 4, 1'b1, 1'b0, 32'h44332211));
    send(1, 1'b1, 1'b0, 8'h44);
    tests_run++;
    if (a_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_edge_n got out_valid %0d want 0", a_out_valid);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    tests_run++;
    if (a_out_valid !== 1'b1 || a_out_lane !== 2'd1) begin
      tests_failed++;
      $display("FAIL latency_edge_n1 got out_valid %0d lane %0d want 1 lane 1", a_out_valid, a_out_lane);
    end
  endtask

  task automatic test_partial_a();
    send(0, 1'b1, 1'b1, 8'hAA);
    send(0, 1'b1, 1'b0, 8'hBB);
    a_q.push_back(mk_exp(0, 2, 1'b1, 1'b1, 32'h0000BBAA));
    send(0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_append_nosop_a();
    send(2, 1'b1, 1'b0, 8'h01);
    send(2, 1'b1, 1'b0, 8'h02);
    send(2, 1'b1, 1'b0, 8'h03);
    a_q.push_back(mk_exp(2, 4, 1'b0, 1'b0, 32'h04030201));
    send(2, 1'b1, 1'b0, 8'h04);
  endtask

  task automatic test_new_packet_a();
    send(1, 1'b1, 1'b1, 8'h55);
    send(1, 1'b1, 1'b0, 8'h66);
    a_q.push_back(mk_exp(1, 2, 1'b1, 1'b1, 32'h00006655));
    send(1, 1'b1, 1'b1, 8'h77);
    a_q.push_back(mk_exp(1, 1, 1'b1, 1'b1, 32'h00000077));
    send(1, 1'b0, 1'b0, 8'h00);
    send(1, 1'b0, 1'b1, 8'h99);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    tests_run++;
    if (a_q.size() != 0 || a_drop !== 16'd0) begin
      tests_failed++;
      $display("FAIL a_drain got pending %0d drop %0d want 0 and 0", a_q.size(), a_drop);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  d;
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < 4; l++) begin
        d = 8'(16 * l + k + 1);
        if (k == 3) begin
          w = {8'(16 * l + 4), 8'(16 * l + 3), 8'(16 * l + 2), 8'(16 * l + 1)};
          b_q.push_back(mk_exp(l, 4, 1'b1, 1'b0, w));
        end
        send(l, 1'b1, (k == 0), d);
        if (k == 3) begin
          tests_run++;
          if (l == 0) begin
            if (b_out_valid !== 1'b0) begin
              tests_failed++;
              $display("FAIL b2b_first got out_valid %0d want 0", b_out_valid);
            end
          end else if (b_out_valid !== 1'b1 || int'(b_out_lane) != l - 1) begin
            tests_failed++;
            $display("FAIL b2b_order got valid %0d lane %0d want 1 lane %0d", b_out_valid, b_out_lane, l - 1);
          end
        end
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    tests_run++;
    if (b_out_valid !== 1'b1 || b_out_lane !== 2'd3) begin
      tests_failed++;
      $display("FAIL b2b_last got valid %0d lane %0d want 1 lane 3", b_out_valid, b_out_lane);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    tests_run++;
    if (b_out_valid !== 1'b0 || b_drop !== 16'd0) begin
      tests_failed++;
      $display("FAIL b2b_idle got valid %0d drop %0d want 0 drop 0", b_out_valid, b_drop);
    end
  endtask

  task automatic test_backpressure();
    exp_t w1;
    w1 = mk_exp(2, 4, 1'b1, 1'b0, 32'h24232221);
    out_ready = 1'b0;
    b_q.push_back(w1);
    send(2, 1'b1, 1'b1, 8'h21);
    send(2, 1'b1, 1'b0, 8'h22);
    send(2, 1'b1, 1'b0, 8'h23);
    send(2, 1'b1, 1'b0, 8'h24);
    b_q.push_back(mk_exp(2, 4, 1'b1, 1'b0, 32'h34333231));
    for (int i = 0; i < 4; i++) begin
      send(2, 1'b1, (i == 0), 8'(8'h31 + i));
      tests_run++;
      if (b_out_valid !== 1'b1 || b_out_lane !== w1.lane || b_out_ctl !== w1.ctl || b_out_data !== w1.data) begin
        tests_failed++;
        $display("FAIL hold_w1 got valid %0d lane %0d ctl %h data %h want 1 lane %0d ctl %h data %h",
                 b_out_valid, b_out_lane, b_out_ctl, b_out_data, w1.lane, w1.ctl, w1.data);
      end
    end
    for (int i = 0; i < 4; i++) send(2, 1'b1, (i == 0), 8'(8'h41 + i));
    tests_run++;
    if (b_drop !== 16'd1 || b_out_data !== w1.data || b_out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop_one got drop %0d data %h valid %0d want 1 data %h valid 1",
               b_drop, b_out_data, b_out_valid, w1.data);
    end
    send(2, 1'b1, 1'b1, 8'h51);
    send(2, 1'b1, 1'b0, 8'h52);
    send(2, 1'b1, 1'b0, 8'h53);
    b_q.push_back(mk_exp(2, 4, 1'b1, 1'b0, 32'h54535251));
    goto_lane(2);
    out_ready = 1'b1;
    step(1'b1, 1'b0, 8'h54, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    tests_run++;
    if (b_drop !== 16'd1 || b_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_refill got drop %0d pending %0d want 1 and 0", b_drop, b_q.size());
    end
  endtask

  task automatic test_slot_sync();
    goto_lane(2);
    step(1'b1, 1'b1, 8'h5A, 1'b1);
    tests_run++;
    if (b_slot !== 2'd0) begin
      tests_failed++;
      $display("FAIL sync_slot0 got %0d want 0", b_slot);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    tests_run++;
    if (b_slot !== 2'd1) begin
      tests_failed++;
      $display("FAIL sync_slot1 got %0d want 1", b_slot);
    end
    b_q.push_back(mk_exp(2, 1, 1'b1, 1'b1, 32'h0000005A));
    send(2, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    tests_run++;
    if (b_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sync_word got pending %0d want 0", b_q.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1, 1'b1, (i == 0), 8'(8'h61 + i));
    for (int i = 0; i < 4; i++) send(1, 1'b1, (i == 0), 8'(8'h71 + i));
    for (int i = 0; i < 3; i++) send(0, 1'b1, (i == 0), 8'(8'h81 + i));
    tests_run++;
    if (b_out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_word got valid %0d want 1", b_out_valid);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({b_out_valid, b_out_lane, b_out_ctl, b_out_data, b_drop, b_slot} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset got v%0d lane %0d ctl %h data %h drop %0d slot %0d want all 0",
               b_out_valid, b_out_lane, b_out_ctl, b_out_data, b_drop, b_slot);
    end
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    tests_run++;
    if (b_out_valid !== 1'b0 || b_drop !== 16'd0) begin
      tests_failed++;
      $display("FAIL post_reset got valid %0d drop %0d want 0 and 0", b_out_valid, b_drop);
    end
  endtask

  initial begin
    sel_a         = 1'b1;
    in_valid      = 1'b0;
    in_new_packet = 1'b0;
    in_data       = 8'h00;
    slot_sync     = 1'b0;
    out_ready     = 1'b1;

    test_reset();
    test_word_a();
    test_partial_a();
    test_append_nosop_a();
    test_new_packet_a();

    sel_a = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    test_back_to_back();
    test_backpressure();
    test_slot_sync();
    test_reset_mid();

    tests_run++;
    if (a_q.size() != 0 || b_q.size() != 0) begin
      tests_failed++;
      $display("FAIL final_queues got a %0d b %0d want 0 and 0", a_q.size(), b_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
